// File: rtl/gray_encoder_tx.sv
// gray_encoder_tx: accepts a 4-bit binary word, converts it to Gray code and
// sends it as a framed serial word: start bit (low), four data bits MSB-first,
// stop bit (high). Every bit lasts BIT_CYCLES clocks. Words above LIMIT are
// rejected with a one-cycle error pulse.
module gray_encoder_tx #(
  parameter int unsigned BIT_CYCLES = 4,
  parameter int unsigned LIMIT      = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] binary_code,
  input  logic       valid_in,
  output logic       ready_out,
  output logic [3:0] gray_code,
  output logic       serial_out,
  output logic       frame_out,
  output logic       done,
  output logic       error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic [1:0] bit_idx;
  logic       accept;
  logic       in_range;
  logic       bit_end;

  // Handshake, range check and end-of-bit-period detection
  always_comb begin
    ready_out = (state == IDLE) && !rst;
    accept    = valid_in && ready_out;
    in_range  = (32'(binary_code) <= LIMIT);
    bit_end   = (cnt == 8'(BIT_CYCLES - 1));
  end

  // State register plus bit-period counter and data bit index
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        // both counters restart on every state change
        cnt     <= '0;
        bit_idx <= '0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          cnt     <= '0;
          bit_idx <= bit_idx + 2'd1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept && in_range)          state_next = START;
      START: if (bit_end)                     state_next = DATA;
      DATA:  if (bit_end && bit_idx == 2'd3)  state_next = STOP;
      STOP:  if (bit_end)                     state_next = IDLE;
      default:                                state_next = IDLE;
    endcase
  end

  // Registered Gray word and one-cycle done/error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_code <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done  <= (state == STOP) && (state_next == IDLE);
      error <= accept && !in_range;
      if (accept && in_range) begin
        gray_code <= binary_code ^ (binary_code >> 1);
      end
    end
  end

  // Serial line and frame indicator decoded from the current state
  always_comb begin
    serial_out = 1'b1;
    frame_out  = 1'b0;
    case (state)
      IDLE:  begin serial_out = 1'b1; frame_out = 1'b0; end
      START: begin serial_out = 1'b0; frame_out = 1'b0; end
      DATA:  begin serial_out = gray_code[2'd3 - bit_idx]; frame_out = 1'b1; end
      STOP:  begin serial_out = 1'b1; frame_out = 1'b0; end
      default: begin serial_out = 1'b1; frame_out = 1'b0; end
    endcase
  end

endmodule
